// File: rtl/esdi_cmd_responder.sv
// ESDI serial command receiver and status transmitter (drive side).
// Handshakes 17-bit odd-parity frames with the host over req/ack.
module esdi_cmd_responder #(
    parameter int unsigned ACK_DELAY     = 6,
    parameter int unsigned DATA_SETUP    = 6,
    parameter int unsigned BIT_TIMEOUT   = 1_000_000,
    parameter logic [15:0] QUERY_OPCODES = 16'h0003
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic        esdi_command_complete,
    output logic        esdi_attention,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_data,
    output logic        cmd_parity_err,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [15:0] resp_data,
    input  logic        complete_strobe,
    input  logic        attention_in,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int unsigned MAX_DLY = (ACK_DELAY > DATA_SETUP) ? ACK_DELAY : DATA_SETUP;
    localparam int unsigned MAX_CNT = (BIT_TIMEOUT > MAX_DLY) ? BIT_TIMEOUT : MAX_DLY;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [4:0] LAST_BIT = 5'd17;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_ACKDLY = 3'd1;
    localparam logic [2:0] RX_REL    = 3'd2;
    localparam logic [2:0] TX_REQ    = 3'd3;
    localparam logic [2:0] TX_LOAD   = 3'd4;
    localparam logic [2:0] TX_SETUP  = 3'd5;
    localparam logic [2:0] TX_REL    = 3'd6;

    // synchronizers plus one extra req stage for edge detection
    logic r_req_s1, r_req_s2, r_req_d;
    logic r_dat_s1, r_dat_s2;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit_cnt;
    logic [16:0]      r_rx_sh;
    logic [16:0]      r_tx_sh;
    logic             r_ack;
    logic             r_confstat;
    logic             r_cc;
    logic             r_attn;
    logic             r_cmd_valid;
    logic [15:0]      r_cmd_data;
    logic             r_cmd_perr;
    logic             r_resp_ready;
    logic             r_err_to;
    logic             r_err_ovr;

    logic [2:0]       w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [4:0]       w_bit_cnt;
    logic [16:0]      w_rx_sh;
    logic [16:0]      w_tx_sh;
    logic             w_ack;
    logic             w_confstat;
    logic             w_cc;
    logic             w_cmd_valid;
    logic [15:0]      w_cmd_data;
    logic             w_cmd_perr;
    logic             w_resp_ready;
    logic             w_err_to;
    logic             w_err_ovr;
    logic             w_timeout;

    logic        w_req_fall;
    logic        w_req_high;
    logic [15:0] w_rx_data;
    logic        w_par_ok;
    logic        w_to_hit;

    assign w_req_fall = r_req_d & ~r_req_s2;
    assign w_req_high = r_req_s2;
    assign w_rx_data  = r_rx_sh[16:1];
    assign w_par_ok   = (r_rx_sh[0] == ~^w_rx_data);
    assign w_to_hit   = (r_cnt == CNT_W'(BIT_TIMEOUT - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_req_s1 <= 1'b1;
            r_req_s2 <= 1'b1;
            r_req_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_req_s1 <= esdi_transfer_req;
            r_req_s2 <= r_req_s1;
            r_req_d  <= r_req_s2;
            r_dat_s1 <= esdi_command_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // next-state and next-output logic
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt + CNT_W'(1);
        w_bit_cnt    = r_bit_cnt;
        w_rx_sh      = r_rx_sh;
        w_tx_sh      = r_tx_sh;
        w_ack        = r_ack;
        w_confstat   = r_confstat;
        w_cc         = r_cc;
        w_cmd_valid  = r_cmd_valid & ~cmd_ready;
        w_cmd_data   = r_cmd_data;
        w_cmd_perr   = r_cmd_perr;
        w_err_to     = 1'b0;
        w_err_ovr    = 1'b0;
        w_timeout    = 1'b0;
        w_resp_ready = 1'b0;

        case (r_state)
            RX_IDLE: begin
                if (w_req_fall) begin
                    w_rx_sh   = {r_rx_sh[15:0], ~r_dat_s2};
                    w_bit_cnt = r_bit_cnt + 5'd1;
                    w_cnt     = '0;
                    w_state   = RX_ACKDLY;
                    if (r_bit_cnt == 5'd0) begin
                        w_cc = 1'b1;
                    end
                end else if (r_bit_cnt != 5'd0 && w_to_hit) begin
                    w_timeout = 1'b1;
                end
            end
            RX_ACKDLY: begin
                if (r_cnt == CNT_W'(ACK_DELAY - 1)) begin
                    w_ack   = 1'b0;
                    w_cnt   = '0;
                    w_state = RX_REL;
                end
            end
            RX_REL: begin
                if (w_req_high) begin
                    w_ack = 1'b1;
                    w_cnt = '0;
                    if (r_bit_cnt == LAST_BIT) begin
                        // an unaccepted word is overwritten by the newer one
                        w_err_ovr   = r_cmd_valid & ~cmd_ready;
                        w_cmd_valid = 1'b1;
                        w_cmd_data  = w_rx_data;
                        w_cmd_perr  = ~w_par_ok;
                        w_bit_cnt   = 5'd0;
                        w_state     = (QUERY_OPCODES[w_rx_data[15:12]] && w_par_ok) ? TX_REQ : RX_IDLE;
                    end else begin
                        w_state = RX_IDLE;
                    end
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                end
            end
            TX_REQ: begin
                if (w_req_fall) begin
                    w_cnt = '0;
                    if (r_bit_cnt == 5'd0) begin
                        w_state = TX_LOAD;
                    end else begin
                        w_confstat = ~r_tx_sh[16];
                        w_tx_sh    = {r_tx_sh[15:0], 1'b0};
                        w_bit_cnt  = r_bit_cnt + 5'd1;
                        w_state    = TX_SETUP;
                    end
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                end
            end
            TX_LOAD: begin
                if (r_resp_ready && resp_valid) begin
                    w_tx_sh    = {resp_data[14:0], ~^resp_data, 1'b0};
                    w_confstat = ~resp_data[15];
                    w_bit_cnt  = 5'd1;
                    w_cnt      = '0;
                    w_state    = TX_SETUP;
                end
            end
            TX_SETUP: begin
                if (r_cnt == CNT_W'(DATA_SETUP - 1)) begin
                    w_ack   = 1'b0;
                    w_cnt   = '0;
                    w_state = TX_REL;
                end
            end
            TX_REL: begin
                if (w_req_high) begin
                    w_ack = 1'b1;
                    w_cnt = '0;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_confstat = 1'b1;
                        w_cc       = 1'b0;
                        w_bit_cnt  = 5'd0;
                        w_state    = RX_IDLE;
                    end else begin
                        w_state = TX_REQ;
                    end
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_state   = RX_IDLE;
                w_bit_cnt = 5'd0;
                w_cnt     = '0;
            end
        endcase

        // a stalled host abandons the frame and returns the wire to idle
        if (w_timeout) begin
            w_err_to   = 1'b1;
            w_ack      = 1'b1;
            w_confstat = 1'b1;
            w_state    = RX_IDLE;
            w_bit_cnt  = 5'd0;
            w_cnt      = '0;
            w_rx_sh    = '0;
        end

        if (complete_strobe) begin
            w_cc = 1'b0;
        end

        w_resp_ready = (w_state == TX_LOAD);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= 5'd0;
            r_rx_sh      <= '0;
            r_tx_sh      <= '0;
            r_ack        <= 1'b1;
            r_confstat   <= 1'b1;
            r_cc         <= 1'b1;
            r_attn       <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_cmd_data   <= '0;
            r_cmd_perr   <= 1'b0;
            r_resp_ready <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_ovr    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_bit_cnt    <= w_bit_cnt;
            r_rx_sh      <= w_rx_sh;
            r_tx_sh      <= w_tx_sh;
            r_ack        <= w_ack;
            r_confstat   <= w_confstat;
            r_cc         <= w_cc;
            r_attn       <= ~attention_in;
            r_cmd_valid  <= w_cmd_valid;
            r_cmd_data   <= w_cmd_data;
            r_cmd_perr   <= w_cmd_perr;
            r_resp_ready <= w_resp_ready;
            r_err_to     <= w_err_to;
            r_err_ovr    <= w_err_ovr;
        end
    end

    assign esdi_transfer_ack     = r_ack;
    assign esdi_confstat_data    = r_confstat;
    assign esdi_command_complete = r_cc;
    assign esdi_attention        = r_attn;
    assign cmd_valid             = r_cmd_valid;
    assign cmd_data              = r_cmd_data;
    assign cmd_parity_err        = r_cmd_perr;
    assign resp_ready            = r_resp_ready;
    assign err_timeout           = r_err_to;
    assign err_overrun           = r_err_ovr;

endmodule
